// File: rtl/jtag_unlock_ctrl_pkg.sv
// Shared types and default geometry for the debug-unlock controller and its lock register.
package jtag_lock_pkg;

  localparam int DEF_WORD_W    = 6;
  localparam int DEF_KEY_WORDS = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    CHECK    = 3'd2,
    UNLOCKED = 3'd3,
    LOCKOUT  = 3'd4
  } unlock_state_e;

  // States in which the key stream may hand over a word.
  function automatic logic accepts_key(input unlock_state_e st);
    return (st == IDLE) || (st == COLLECT);
  endfunction

endpackage

// File: rtl/jtag_unlock_ctrl_if.sv
// Key-word stream from the JTAG data path into the unlock controller.
interface jtag_unlock_ctrl_if
  import jtag_lock_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) ();

  logic              key_valid;
  logic              key_ready;
  logic [WORD_W-1:0] key_data;
  logic              key_last;

  modport master (output key_valid, output key_data, output key_last, input key_ready);
  modport slave  (input key_valid, input key_data, input key_last, output key_ready);

endinterface

// File: rtl/jtag_unlock_ctrl_lockout_timer.sv
// Down-counter timing the lockout window; done flags the final counted cycle.
module lockout_timer #(
  parameter int LOCKOUT_CYCLES = 256,
  localparam int TMR_W = $clog2(LOCKOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic done
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  // Next count: load the full window, otherwise step down while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = TMR_W'(LOCKOUT_CYCLES);
    end else if (count && (cnt_q != '0)) begin
      cnt_d = cnt_q - TMR_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = count && (cnt_q == TMR_W'(1));

endmodule

// File: rtl/jtag_unlock_ctrl.sv
// Debug-unlock initiator: collects a key, compares it in constant time and strobes the lock register.
module jtag_unlock_ctrl
  import jtag_lock_pkg::*;
#(
  parameter int                          WORD_W         = DEF_WORD_W,
  parameter int                          KEY_WORDS      = DEF_KEY_WORDS,
  parameter logic [WORD_W*KEY_WORDS-1:0] SECRET         = 24'h5A3C96,
  parameter int                          MAX_TRIES      = 3,
  parameter int                          LOCKOUT_CYCLES = 256,
  localparam int IDX_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1,
  localparam int CNT_W = $clog2(MAX_TRIES + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  jtag_unlock_ctrl_if.slave        key_if,
  input  logic                     relock,
  output logic                     lock_en,
  output logic                     lock_value,
  output logic                     unlocked,
  output logic                     locked_out,
  output logic [CNT_W-1:0]         fail_cnt
);

  unlock_state_e    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             lock_en_q, lock_en_d;
  logic             lock_value_q, lock_value_d;
  logic             key_ready_q, key_ready_d;
  logic             unlocked_q, unlocked_d;
  logic             locked_out_q, locked_out_d;

  logic              xfer;
  logic              final_word;
  logic              word_ne;
  logic [WORD_W-1:0] secret_word;
  logic              tmr_load, tmr_count, tmr_done;

  assign xfer        = key_if.key_valid && key_ready_q;
  assign final_word  = (idx_q == IDX_W'(KEY_WORDS - 1));
  assign secret_word = SECRET[(KEY_WORDS - 1 - int'(idx_q)) * WORD_W +: WORD_W];
  assign word_ne     = (key_if.key_data != secret_word);

  lockout_timer #(
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) u_lockout_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .count (tmr_count),
    .done  (tmr_done)
  );

  // Next-state, attempt bookkeeping and the strobe to be registered.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mismatch_d   = mismatch_q;
    fail_cnt_d   = fail_cnt_q;
    lock_en_d    = 1'b0;
    lock_value_d = 1'b0;
    tmr_load     = 1'b0;
    tmr_count    = 1'b0;

    case (state_q)
      IDLE, COLLECT: begin
        if (xfer) begin
          // Every word is compared, so timing never depends on where a mismatch sits.
          mismatch_d = mismatch_q || word_ne;
          if (final_word) begin
            mismatch_d = mismatch_q || word_ne || !key_if.key_last;
            idx_d      = '0;
            state_d    = CHECK;
          end else if (key_if.key_last) begin
            mismatch_d = 1'b1;
            idx_d      = '0;
            state_d    = CHECK;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = COLLECT;
          end
        end else begin
          state_d = state_q;
        end
      end

      CHECK: begin
        mismatch_d = 1'b0;
        if (!mismatch_q) begin
          state_d      = UNLOCKED;
          fail_cnt_d   = '0;
          lock_en_d    = 1'b1;
          lock_value_d = 1'b1;
        end else begin
          if (fail_cnt_q < CNT_W'(MAX_TRIES)) begin
            fail_cnt_d = fail_cnt_q + CNT_W'(1);
          end else begin
            fail_cnt_d = fail_cnt_q;
          end
          if (fail_cnt_d == CNT_W'(MAX_TRIES)) begin
            state_d  = LOCKOUT;
            tmr_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      UNLOCKED: begin
        if (relock) begin
          state_d      = IDLE;
          lock_en_d    = 1'b1;
          lock_value_d = 1'b0;
        end else begin
          state_d = UNLOCKED;
        end
      end

      LOCKOUT: begin
        tmr_count = 1'b1;
        if (tmr_done) begin
          state_d    = IDLE;
          fail_cnt_d = '0;
        end else begin
          state_d = LOCKOUT;
        end
      end

      default: begin
        state_d    = IDLE;
        idx_d      = '0;
        mismatch_d = 1'b0;
      end
    endcase

    key_ready_d  = accepts_key(state_d);
    unlocked_d   = (state_d == UNLOCKED);
    locked_out_d = (state_d == LOCKOUT);
  end

  // State, attempt tracking and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      mismatch_q   <= 1'b0;
      fail_cnt_q   <= '0;
      lock_en_q    <= 1'b0;
      lock_value_q <= 1'b0;
      key_ready_q  <= 1'b1;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mismatch_q   <= mismatch_d;
      fail_cnt_q   <= fail_cnt_d;
      lock_en_q    <= lock_en_d;
      lock_value_q <= lock_value_d;
      key_ready_q  <= key_ready_d;
      unlocked_q   <= unlocked_d;
      locked_out_q <= locked_out_d;
    end
  end

  assign key_if.key_ready = key_ready_q;
  assign lock_en          = lock_en_q;
  assign lock_value       = lock_value_q;
  assign unlocked         = unlocked_q;
  assign locked_out       = locked_out_q;
  assign fail_cnt         = fail_cnt_q;

endmodule

// File: tb/tb_jtag_unlock_ctrl.sv
// Randomized and directed bench for jtag_unlock_ctrl against a transaction-level reference model.
module tb_jtag_unlock_ctrl;

  localparam int          WORD_W         = 6;
  localparam int          KEY_WORDS      = 4;
  localparam logic [23:0] SECRET         = 24'h5A3C96;
  localparam int          MAX_TRIES      = 3;
  localparam int          LOCKOUT_CYCLES = 256;

  logic       clk;
  logic       reset;
  logic       relock;
  logic       lock_en;
  logic       lock_value;
  logic       unlocked;
  logic       locked_out;
  logic [1:0] fail_cnt;

  jtag_unlock_ctrl_if #(.WORD_W(WORD_W)) key_if ();

  jtag_unlock_ctrl #(
    .WORD_W         (WORD_W),
    .KEY_WORDS      (KEY_WORDS),
    .SECRET         (SECRET),
    .MAX_TRIES      (MAX_TRIES),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_if     (key_if),
    .relock     (relock),
    .lock_en    (lock_en),
    .lock_value (lock_value),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .fail_cnt   (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: an attempt is a list of words, judged once it ends.
  int secret_w [KEY_WORDS];
  int attempt [$];
  bit m_judging, m_verdict_ok, m_grant, m_en, m_val;
  int m_fails, m_lock_left;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_step();
    bit ok;
    m_en  = 1'b0;
    m_val = 1'b0;
    if (reset) begin
      attempt.delete();
      m_judging   = 1'b0;
      m_grant     = 1'b0;
      m_fails     = 0;
      m_lock_left = 0;
      return;
    end
    if (m_judging) begin
      m_judging = 1'b0;
      if (m_verdict_ok) begin
        m_grant = 1'b1;
        m_fails = 0;
        m_en    = 1'b1;
        m_val   = 1'b1;
      end else begin
        if (m_fails < MAX_TRIES) m_fails++;
        if (m_fails == MAX_TRIES) m_lock_left = LOCKOUT_CYCLES;
      end
    end else if (m_grant) begin
      if (relock) begin
        m_grant = 1'b0;
        m_en    = 1'b1;
      end
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (key_if.key_valid) begin
      attempt.push_back(int'(key_if.key_data));
      if (key_if.key_last || attempt.size() == KEY_WORDS) begin
        ok = key_if.key_last && (attempt.size() == KEY_WORDS);
        foreach (attempt[i]) if (attempt[i] != secret_w[i]) ok = 1'b0;
        m_verdict_ok = ok;
        attempt.delete();
        m_judging = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("key_ready",  32'(key_if.key_ready), 32'(!m_judging && !m_grant && m_lock_left == 0));
    check_eq("lock_en",    32'(lock_en),    32'(m_en));
    check_eq("lock_value", 32'(lock_value), 32'(m_val));
    check_eq("unlocked",   32'(unlocked),   32'(m_grant));
    check_eq("locked_out", 32'(locked_out), 32'(m_lock_left > 0));
    check_eq("fail_cnt",   32'(fail_cnt),   32'(m_fails));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    key_if.key_valid = 1'b0;
    key_if.key_data  = '0;
    key_if.key_last  = 1'b0;
    relock           = 1'b0;
  endtask

  // Sends words of a packed key, word 0 in the MSBs, ending after word last_at.
  task automatic send_key(input logic [23:0] key, input int last_at, input int n_words);
    for (int i = 0; i < n_words; i++) begin
      key_if.key_valid = 1'b1;
      key_if.key_data  = key[23 - 6*i -: 6];
      key_if.key_last  = (i == last_at);
      cycle();
    end
    idle_inputs();
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  logic [23:0] wrong_a;
  logic [23:0] wrong_b;

  initial begin
    for (int i = 0; i < KEY_WORDS; i++)
      secret_w[i] = int'((SECRET >> (WORD_W * (KEY_WORDS - 1 - i))) & 24'h3F);
    wrong_a = {6'd16, 6'd28, 6'd58, 6'd23};
    wrong_b = {6'd16, 6'd28, 6'd58, 6'd22};

    idle_inputs();
    reset = 1'b1;
    wait_cycles(3);
    check_eq("rst_ready", 32'(key_if.key_ready), 32'd1);
    check_eq("rst_fail",  32'(fail_cnt), 32'd0);
    reset = 1'b0;
    wait_cycles(2);

    // Correct key, then relock.
    send_key(SECRET, 3, 4);
    cycle();
    check_eq("grant_en",   32'(lock_en), 32'd1);
    check_eq("grant_val",  32'(lock_value), 32'd1);
    wait_cycles(2);
    check_eq("grant_hold", 32'(unlocked), 32'd1);
    relock = 1'b1;
    cycle();
    relock = 1'b0;
    check_eq("relock_en",  32'(lock_en), 32'd1);
    check_eq("relock_val", 32'(lock_value), 32'd0);
    check_eq("relock_st",  32'(unlocked), 32'd0);
    wait_cycles(2);

    // Wrong keys, relock ignored outside UNLOCKED, then lockout.
    send_key(wrong_a, 3, 4);
    relock = 1'b1;
    cycle();
    relock = 1'b0;
    check_eq("fail1_cnt",   32'(fail_cnt), 32'd1);
    check_eq("fail1_ready", 32'(key_if.key_ready), 32'd1);
    send_key(wrong_b, 3, 4);
    wait_cycles(1);
    send_key(wrong_a, 3, 4);
    wait_cycles(2);
    check_eq("lockout_st",  32'(locked_out), 32'd1);
    check_eq("lockout_rdy", 32'(key_if.key_ready), 32'd0);
    send_key(SECRET, 3, 4);
    wait_cycles(LOCKOUT_CYCLES);
    check_eq("lockout_end", 32'(fail_cnt), 32'd0);
    send_key(SECRET, 3, 4);
    wait_cycles(2);
    check_eq("post_lock_grant", 32'(unlocked), 32'd1);
    relock = 1'b1;
    cycle();
    relock = 1'b0;

    // Early key_last and missing key_last.
    send_key(SECRET, 1, 2);
    wait_cycles(1);
    check_eq("early_last", 32'(fail_cnt), 32'd1);
    send_key(SECRET, 9, 4);
    wait_cycles(1);
    send_key(SECRET, 3, 4);
    wait_cycles(2);
    check_eq("after_early", 32'(unlocked), 32'd1);
    relock = 1'b1;
    cycle();
    relock = 1'b0;

    // Reset mid-attempt and mid-lockout.
    send_key(SECRET, 9, 2);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_eq("rst_mid_ready", 32'(key_if.key_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      send_key(wrong_a, 3, 4);
      wait_cycles(1);
    end
    wait_cycles(20);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_eq("rst_lock_out",  32'(locked_out), 32'd0);
    check_eq("rst_lock_fail", 32'(fail_cnt), 32'd0);
    wait_cycles(2);

    // Randomized traffic.
    for (int c = 0; c < 6000; c++) begin
      int pos;
      pos = attempt.size();
      key_if.key_valid = ($urandom_range(0, 9) < 7);
      key_if.key_data  = ($urandom_range(0, 3) != 0) ? 6'(secret_w[pos]) : 6'($urandom_range(0, 63));
      key_if.key_last  = (pos == KEY_WORDS - 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
      relock           = ($urandom_range(0, 9) == 0);
      reset            = ($urandom_range(0, 399) == 0);
      cycle();
    end
    idle_inputs();
    reset = 1'b0;
    wait_cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
